pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer_if.sv | 24 ++
 rtl/pc_sequencer.sv | 62 ++++++
 tb/tb_pc_sequencer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: jump-redirect, fetch and link-writeback signals of the PC sequencer
interface pc_sequencer_if;
  logic        jmp_valid;
  logic        jmp_ready;
  logic [8:0]  jmp_target;
  logic [8:0]  jmp_link;
  logic        jmp_is_link;
  logic        stall;
  logic        halt;
  logic [8:0]  pc;
  logic        pc_valid;
  logic        flush;
  logic        lr_we;
  logic [4:0]  lr_addr;
  logic [31:0] lr_data;
  modport master (
    output jmp_valid, jmp_target, jmp_link, jmp_is_link, stall, halt,
    input  jmp_ready, pc, pc_valid, flush, lr_we, lr_addr, lr_data
  );
  modport slave (
    input  jmp_valid, jmp_target, jmp_link, jmp_is_link, stall, halt,
    output jmp_ready, pc, pc_valid, flush, lr_we, lr_addr, lr_data
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch PC sequencer with jump redirect/flush; define PC_LINK_WB_EN for jal link writeback
module pc_sequencer (
  input  logic          clk,
  input  logic          rst_n,
  pc_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, HALTED} state_t;
  state_t     r_state, w_state;
  logic [8:0] r_pc, w_pc;
  logic       r_flush, w_take;
  always_comb begin
    w_state = r_state;
    w_pc    = r_pc;
    w_take  = 1'b0;
    case (r_state)
      IDLE:   w_state = RUN;
      RUN:
        if (bus.jmp_valid) begin
          w_take  = 1'b1;
          w_pc    = bus.jmp_target;
          w_state = FLUSH;
        end else if (bus.halt) w_state = HALTED;
        else if (!bus.stall) w_pc = r_pc + 9'd1;
      FLUSH:  w_state = bus.halt ? HALTED : RUN;
      default: w_state = HALTED;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_pc    <= '0;
      r_flush <= 1'b0;
    end else begin
      r_state <= w_state;
      r_pc    <= w_pc;
      r_flush <= w_take;
    end
  assign bus.jmp_ready = r_state == RUN;
  assign bus.pc_valid  = r_state == RUN;
  assign bus.pc        = r_pc;
  assign bus.flush     = r_flush;
  assign bus.lr_addr   = 5'd31;
`ifdef PC_LINK_WB_EN
  logic       r_lr_we;
  logic [8:0] r_link;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_lr_we <= 1'b0;
      r_link  <= '0;
    end else begin
      r_lr_we <= w_take & bus.jmp_is_link;
      if (w_take & bus.jmp_is_link) r_link <= bus.jmp_link;
    end
  assign bus.lr_we   = r_lr_we;
  assign bus.lr_data = {23'b0, r_link};
`else
  logic w_unused;
  assign w_unused    = ^{bus.jmp_link, bus.jmp_is_link};
  assign bus.lr_we   = 1'b0;
  assign bus.lr_data = '0;
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard bench; a boolean-flag reference model queues expectations, a monitor compares
module tb_pc_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  pc_sequencer_if bus();
  pc_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`ifdef PC_LINK_WB_EN
  localparam bit LINK = 1'b1;
`else
  localparam bit LINK = 1'b0;
`endif
  typedef struct packed {
    logic [8:0]  pc;
    logic        pv;
    logic        fl;
    logic        rdy;
    logic        we;
    logic [31:0] data;
  } exp_t;
  exp_t q[$];
  int n_tests = 0;
  int n_fail = 0;
  int m_pc = 0;
  int m_link = 0;
  bit m_booted = 0, m_kill = 0, m_stop = 0, m_we = 0, m_acc = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic exp_t snap();
    exp_t e;
    e.pc   = m_pc[8:0];
    e.pv   = m_booted && !m_kill && !m_stop;
    e.rdy  = e.pv;
    e.fl   = m_kill;
    e.we   = m_we;
    e.data = {23'b0, m_link[8:0]};
    return e;
  endfunction
  task automatic cyc(input bit jv, input int tgt, input int lnk, input bit il, input bit st, input bit hl);
    bit run;
    @(negedge clk);
    rst_n = 1'b1;
    bus.jmp_valid   = jv;
    bus.jmp_target  = tgt[8:0];
    bus.jmp_link    = lnk[8:0];
    bus.jmp_is_link = il;
    bus.stall       = st;
    bus.halt        = hl;
    run   = m_booted && !m_kill && !m_stop;
    m_we  = 0;
    m_acc = 0;
    if (!m_booted) m_booted = 1;
    else if (m_kill) begin
      m_kill = 0;
      m_stop = hl;
    end else if (run) begin
      if (jv) begin
        m_acc  = 1;
        m_pc   = tgt % 512;
        m_kill = 1;
        if (LINK && il) begin
          m_we   = 1;
          m_link = lnk % 512;
        end
      end else if (hl) m_stop = 1;
      else if (!st) m_pc = (m_pc + 1) % 512;
    end
    q.push_back(snap());
  endtask
  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst_n = 1'b0;
      {bus.jmp_valid, bus.jmp_is_link, bus.stall, bus.halt} = '0;
      if (i == 0) begin
        #1;
        check("async_flush", bus.flush, 0);
        check("async_lr_we", bus.lr_we, 0);
        check("async_pc", bus.pc, 0);
        check("async_pc_valid", bus.pc_valid, 0);
        check("async_ready", bus.jmp_ready, 0);
        check("async_lr_data", bus.lr_data, 0);
      end
      m_pc = 0; m_link = 0;
      m_booted = 0; m_kill = 0; m_stop = 0; m_we = 0; m_acc = 0;
      q.push_back(snap());
    end
  endtask
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("pc", bus.pc, e.pc);
        check("pc_valid", bus.pc_valid, e.pv);
        check("flush", bus.flush, e.fl);
        check("jmp_ready", bus.jmp_ready, e.rdy);
        check("lr_we", bus.lr_we, e.we);
        check("lr_data", bus.lr_data, e.data);
        check("lr_addr", bus.lr_addr, 31);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "timeout");
  end
  initial begin : driver
    bit pend, jv, il;
    int tgt, lnk;
    bus.jmp_valid = 0; bus.jmp_target = '0; bus.jmp_link = '0;
    bus.jmp_is_link = 0; bus.stall = 0; bus.halt = 0;
    do_reset(2);
    repeat (5) cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 511, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 'h040, 'h013, 1, 1, 1);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 'h100, 0, 0, 0, 0);
    cyc(1, 'h180, 0, 0, 0, 0);
    cyc(1, 'h180, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 'h055, 'h013, 1, 0, 0);
    do_reset(2);
    repeat (2) cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 'h020, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    repeat (4) cyc(1, 'h077, 'h011, 1, 0, 0);
    do_reset(1);
    repeat (3) cyc(0, 0, 0, 0, 0, 0);
    pend = 0; jv = 0; il = 0; tgt = 0; lnk = 0;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 59) == 0 || (m_stop && $urandom_range(0, 3) == 0)) begin
        do_reset(1 + $urandom_range(0, 1));
        pend = 0;
      end else begin
        if (!pend) begin
          jv  = $urandom_range(0, 3) == 0;
          tgt = $urandom_range(0, 511);
          lnk = $urandom_range(0, 511);
          il  = $urandom_range(0, 1) == 1;
        end
        cyc(jv, tgt, lnk, il, $urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0);
        pend = jv && !m_acc;
      end
    end
    repeat (3) @(posedge clk);
    #2;
    check("drain", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
